// File: rtl/thunderbird_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : thunderbird_seq                                                 |
// | Brief  : One-side Thunderbird tail-light sequencer, cumulative A->B->C.  |
// |          Optional macro THUNDERBIRD_MIRROR_EN bit-reverses the right side.|
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module thunderbird_seq #(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       isLeft,
  input  logic       enable,
  output logic [2:0] output_state
);

  localparam int unsigned    CNT_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

  // State encodings double as the lamp pattern for the unmirrored side.
  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_S1   = 3'b001;
  localparam logic [2:0] ST_S2   = 3'b011;
  localparam logic [2:0] ST_S3   = 3'b111;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [2:0]       output_state_q, output_state_d;
  logic             tick;

  assign tick = (step_cnt_q == CNT_MAX);

  // State register, prescaler and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      step_cnt_q     <= '0;
      output_state_q <= 3'b000;
    end else begin
      state_q        <= state_d;
      step_cnt_q     <= step_cnt_d;
      output_state_q <= output_state_d;
    end
  end

  // Prescaler held at zero while idle so the first step lands STEP_DIV cycles after a request.
  always_comb begin
    step_cnt_d = step_cnt_q + 1'b1;
    if ((state_q == ST_IDLE) && !enable) begin
      step_cnt_d = '0;
    end else if (tick) begin
      step_cnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (tick && enable) state_d = ST_S1;
      ST_S1:   if (tick)           state_d = ST_S2;
      ST_S2:   if (tick)           state_d = ST_S3;
      ST_S3:   if (tick)           state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Output decodes the next state so the register tracks the current state with no extra lag.
  always_comb begin
    output_state_d = 3'b000;
    case (state_d)
      ST_S1:   output_state_d = 3'b001;
      ST_S2:   output_state_d = 3'b011;
      ST_S3:   output_state_d = 3'b111;
      default: output_state_d = 3'b000;
    endcase
`ifdef THUNDERBIRD_MIRROR_EN
    if (!isLeft) begin
      output_state_d = {output_state_d[0], output_state_d[1], output_state_d[2]};
    end
`endif
  end

`ifndef THUNDERBIRD_MIRROR_EN
  logic unused_isleft;
  assign unused_isleft = isLeft;
`endif

  assign output_state = output_state_q;

endmodule
`default_nettype wire

// File: tb/tb_thunderbird_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_thunderbird_seq                                              |
// | Brief  : Scoreboard bench for left/right sequencers and a STEP_DIV=3 copy.|
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_thunderbird_seq;

  logic       clk;
  logic       rst;
  logic       en_l, en_r, en_3;
  logic [2:0] out_l, out_r, out_3;

  int total = 0;
  int bad   = 0;

  logic [2:0] q_l[$];
  logic [2:0] q_r[$];
  logic [2:0] q_3[$];

  logic [2:0] pat_l [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
`ifdef THUNDERBIRD_MIRROR_EN
  logic [2:0] pat_r [4] = '{3'b000, 3'b100, 3'b110, 3'b111};
`else
  logic [2:0] pat_r [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
`endif

  int m_l = 0;
  int m_r = 0;

  thunderbird_seq #(.STEP_DIV(1)) u_left (
    .clk(clk), .rst(rst), .isLeft(1'b1), .enable(en_l), .output_state(out_l)
  );

  thunderbird_seq #(.STEP_DIV(1)) u_right (
    .clk(clk), .rst(rst), .isLeft(1'b0), .enable(en_r), .output_state(out_r)
  );

  thunderbird_seq #(.STEP_DIV(3)) u_div3 (
    .clk(clk), .rst(rst), .isLeft(1'b1), .enable(en_3), .output_state(out_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Step index: 0 idle, 1..3 lamps; a request is only taken from idle.
  function automatic int nxt(input int idx, input logic r, input logic e);
    if (r) return 0;
    if (idx == 0) return e ? 1 : 0;
    return (idx == 3) ? 0 : idx + 1;
  endfunction

  task automatic cycle(input logic r, input logic el, input logic er, input logic e3,
                       input logic [2:0] exp3);
    @(negedge clk);
    rst  = r;
    en_l = el;
    en_r = er;
    en_3 = e3;
    m_l  = nxt(m_l, r, el);
    m_r  = nxt(m_r, r, er);
    q_l.push_back(pat_l[m_l]);
    q_r.push_back(pat_r[m_r]);
    q_3.push_back(exp3);
    @(posedge clk);
    #1;
    chk("left",  out_l, q_l.pop_front());
    chk("right", out_r, q_r.pop_front());
    chk("div3",  out_3, q_3.pop_front());
  endtask

  initial begin
    rst  = 1'b1;
    en_l = 1'b1;
    en_r = 1'b1;
    en_3 = 1'b0;

    // Reset with enable asserted, then the first request edge.
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'b000);

    // Continuous request on both sides, then release.
    repeat (10) cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    repeat (4)  cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

    // Single-cycle pulse, plus a pulse while mid-sequence that must be ignored.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

    // Reset while at 011, then restart.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (5) cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'b000);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

    // Independent sides: right alone, then left alone.
    repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

    // STEP_DIV=3: each pattern lasts 3 cycles, first 001 after the 3rd edge.
    for (int k = 1; k <= 15; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, pat_l[(k / 3) % 4]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/thunderbird_seq.md
Name: thunderbird_seq

Overview:
- Sequential turn-signal lamp sequencer for one side of a Thunderbird-style tail light: three lamps, lit inner-to-outer in a cumulative pattern, then all off, repeating.
- The top level instantiates one copy per side (left and right).
- `isLeft` tags the side; `enable` is that side's turn-signal request.
- `output_state[2:0]` drives lamps C/B/A (bit 2 = C outer, bit 0 = A inner).

Parameters:
- STEP_DIV, default 1: number of clock cycles per sequence step. Legal range 1..65535. A value of 1 means the sequence advances every clock.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- isLeft  input  1  side tag; static during operation (1 = left instance, 0 = right instance).
- enable  input  1  turn-signal request for this side, level sensitive.
- output_state  output  3  registered lamp pattern {C,B,A}.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high.
  - All state updates occur on the rising edge of `clk`.
- Prescaler:
  - Counter `step_cnt`, width ceil(log2(STEP_DIV)), minimum 1 bit.
  - Counts 0..STEP_DIV-1 and wraps to 0.
  - `tick` = (`step_cnt` == STEP_DIV-1). With STEP_DIV = 1, `tick` is constantly 1.
  - The counter resets to 0 while the FSM is in IDLE and `enable` = 0. The first step after a request is therefore exactly STEP_DIV cycles later, or immediate when STEP_DIV = 1.
- FSM states and their outputs:
  - IDLE = 000
  - S1 = 001
  - S2 = 011
  - S3 = 111
- `output_state` is a register equal to the decode of the current state (Moore). It has no combinational path from `enable`.
- Transitions, taken only on a clock edge with `tick` = 1:
  - IDLE → S1 if `enable` = 1; otherwise stay in IDLE.
  - S1 → S2 unconditionally.
  - S2 → S3 unconditionally.
  - S3 → IDLE unconditionally.
- Latency: with STEP_DIV = 1, `enable` sampled high at edge N gives `output_state` = 001 after edge N.
- Full period is 4 steps. With `enable` held high the pattern repeats: 001, 011, 111, 000, 001, …
- `enable` dropped mid-sequence: the sequence completes through S3 and then returns to IDLE. No abort. IDLE persists while `enable` = 0.
- `enable` pulse shorter than one step: with STEP_DIV = 1 it is seen only if high at an edge while in IDLE. Otherwise it is ignored.
- Reset takes priority over everything. `rst` = 1 at an edge, including mid-sequence, forces IDLE, `output_state` = 000 and `step_cnt` = 0.
- X-safety: any unreachable state encoding recovers to IDLE on the next edge.
- Without MIRROR_EN, `isLeft` has no effect. Left and right instances produce identical patterns, since the A lamp is the inner lamp on both sides.

Optional Feature:
- Macro: THUNDERBIRD_MIRROR_EN.
- When defined, an instance with `isLeft` = 0 emits the bit-reversed pattern: S1 = 100, S2 = 110, S3 = 111.
  - This supports boards that wire the right side's inner lamp to bit 2.
  - Instances with `isLeft` = 1 are unchanged.
  - The bit reversal is applied at the output register, so latency is unchanged.
- When undefined, `isLeft` is ignored and all instances use 001/011/111.

Test Plan:
- Reset: `rst` = 1 for 1 cycle with `enable` = 1 → `output_state` = 000 during and right after reset. The next edge with `rst` = 0 and `enable` = 1 gives 001.
- Continuous left request (STEP_DIV = 1, `isLeft` = 1): `enable` = 1 for 10 cycles → 001, 011, 111, 000, 001, 011, 111, 000, 001, 011. Then `enable` = 0 → 111, 000, and stays at 000.
- Mid-sequence release: `enable` high 1 cycle only → 001, 011, 111, 000, then holds 000.
- Reset mid-sequence: assert `rst` while at 011 → 000 at the next edge, and the sequence restarts from 001 after release.
- Two instances (`isLeft` = 1 and `isLeft` = 0) driven by separate `enable` inputs, both high together → identical, lock-stepped patterns. With THUNDERBIRD_MIRROR_EN defined, the right instance shows 100, 110, 111, 000.
- STEP_DIV = 3: `enable` held high → each pattern value lasts 3 cycles, and the first 001 appears 3 cycles after `enable` rises.
